// File: rtl/lc3b_mem_responder.sv
// LC-3b memory-port responder: fixed-latency word memory with byte-lane writes.
// Answers MAR/MDR read/write strobes with a one-cycle mem_resp pulse.
module lc3b_mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        protocol_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam int WORDS = 2 ** ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam bit DIRECT = (LATENCY == 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("LATENCY must be in 1..15");
  end

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic                 op_wr_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic [15:0]          wdata_q;
  logic [1:0]           be_q;
  logic                 err_q;

  logic accept;
  logic err_set;
  logic commit;
  logic dropped;

  logic [15:0] mem [WORDS];

  logic unused_addr;
  assign unused_addr = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

  // Abort when the latched strobe falls or the opposite strobe rises.
  always_comb begin
    dropped = 1'b0;
    if (op_wr_q) begin
      dropped = !mem_write || mem_read;
    end else begin
      dropped = !mem_read || mem_write;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    err_set = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read ^ mem_write) begin
          accept  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = DIRECT ? RESP : BUSY;
        end else if (mem_read && mem_write) begin
          err_set = 1'b1;
        end
      end
      BUSY: begin
        if (dropped) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = RESP;
            cnt_d   = '0;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        commit  = op_wr_q;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_wr_q <= mem_write;
        idx_q   <= mem_address[ADDR_BITS:1];
        wdata_q <= mem_wdata;
        be_q    <= mem_byte_enable;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (commit && !rst) begin
      if (be_q[1]) begin
        mem[idx_q][15:8] <= wdata_q[15:8];
      end
      if (be_q[0]) begin
        mem[idx_q][7:0] <= wdata_q[7:0];
      end
    end
  end

  always_comb begin
    mem_resp  = (state_q == RESP);
    mem_rdata = '0;
    if (mem_resp && !op_wr_q) begin
      mem_rdata = mem[idx_q];
    end
  end

  assign protocol_err = err_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Bench for lc3b_mem_responder: directed scenarios plus random traffic
// against a word-array reference model.
module tb_lc3b_mem_responder;

  localparam int AB  = 4;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address, mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        protocol_err;

  logic        s_read, s_write;
  logic [1:0]  s_be;
  logic [15:0] s_addr, s_wdata;
  logic        s_resp;
  logic [15:0] s_rdata;
  logic        s_err;

  int total = 0;
  int bad = 0;

  logic [15:0] model [16];

  always #5 clk = ~clk;

  lc3b_mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address),
    .mem_wdata(mem_wdata),
    .mem_resp(mem_resp),
    .mem_rdata(mem_rdata),
    .protocol_err(protocol_err)
  );

  lc3b_mem_responder #(.ADDR_BITS(10), .LATENCY(1)) dut1 (
    .clk(clk),
    .rst(rst),
    .mem_read(s_read),
    .mem_write(s_write),
    .mem_byte_enable(s_be),
    .mem_address(s_addr),
    .mem_wdata(s_wdata),
    .mem_resp(s_resp),
    .mem_rdata(s_rdata),
    .protocol_err(s_err)
  );

  function automatic int widx(input logic [15:0] a);
    return int'((a / 16'd2) % 16'd16);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] o, n,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = o;
    if (be[1]) r[15:8] = n[15:8];
    if (be[0]) r[7:0] = n[7:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the main DUT; updates the model on writes.
  task automatic do_op(input bit wr, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [1:0] be,
                       output logic [15:0] rd, output int lat);
    mem_address = addr;
    mem_wdata = wd;
    mem_byte_enable = be;
    mem_read = !wr;
    mem_write = wr;
    lat = 0;
    rd = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (mem_resp) begin
        lat = i;
        rd = mem_rdata;
        break;
      end
      total++;
      if (mem_rdata !== 16'h0) begin
        bad++;
        $display("FAIL rdata_idle got=%h want=0000", mem_rdata);
      end
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    if (wr && lat != 0) model[widx(addr)] = merge(model[widx(addr)], wd, be);
    tick();
    total++;
    if (mem_resp !== 1'b0 || mem_rdata !== 16'h0) begin
      bad++;
      $display("FAIL resp_single got=%b/%h want=0/0000", mem_resp, mem_rdata);
    end
  endtask

  task automatic chk_lat(input string nm, input int got);
    total++;
    if (got != LAT) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", nm, got, LAT);
    end
  endtask

  task automatic chk_rd(input string nm, input logic [15:0] got,
                        input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s rdata got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_read = 0; mem_write = 0; mem_byte_enable = 0;
    mem_address = 0; mem_wdata = 0;
    s_read = 0; s_write = 0; s_be = 0; s_addr = 0; s_wdata = 0;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (mem_resp !== 1'b0) begin
      bad++; $display("FAIL reset_resp got=%b want=0", mem_resp);
    end
    total++;
    if (mem_rdata !== 16'h0) begin
      bad++; $display("FAIL reset_rdata got=%h want=0000", mem_rdata);
    end
    total++;
    if (protocol_err !== 1'b0) begin
      bad++; $display("FAIL reset_err got=%b want=0", protocol_err);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] rd;
    int lat;
    do_op(1, 16'h0040, 16'h1234, 2'b11, rd, lat);
    chk_lat("basic_wr", lat);
    do_op(0, 16'h0040, 16'h0, 2'b00, rd, lat);
    chk_lat("basic_rd", lat);
    chk_rd("basic_rd", rd, 16'h1234);
  endtask

  task automatic test_byte_lanes();
    logic [15:0] rd;
    int lat;
    do_op(1, 16'h0010, 16'hFFFF, 2'b11, rd, lat);
    do_op(1, 16'h0010, 16'hAB00, 2'b10, rd, lat);
    do_op(0, 16'h0010, 16'h0, 2'b00, rd, lat);
    chk_rd("be10", rd, 16'hABFF);
    do_op(1, 16'h0010, 16'h1111, 2'b00, rd, lat);
    chk_lat("be00_wr", lat);
    do_op(0, 16'h0010, 16'h0, 2'b00, rd, lat);
    chk_rd("be00", rd, 16'hABFF);
    do_op(1, 16'h0010, 16'h00C3, 2'b01, rd, lat);
    do_op(0, 16'h0010, 16'h0, 2'b00, rd, lat);
    chk_rd("be01", rd, 16'hABC3);
  endtask

  task automatic test_alias();
    logic [15:0] rd;
    int lat;
    do_op(1, 16'h0002, 16'h5555, 2'b11, rd, lat);
    do_op(0, 16'h0022, 16'h0, 2'b00, rd, lat);
    chk_rd("alias_0022", rd, 16'h5555);
    do_op(0, 16'h0003, 16'h0, 2'b00, rd, lat);
    chk_rd("bit0_0003", rd, 16'h5555);
  endtask

  task automatic test_random();
    logic [15:0] rd, a, d, want;
    logic [1:0] be;
    int lat;
    for (int i = 0; i < 16; i++) begin
      a = 16'(i * 2 + 32 * $urandom_range(0, 100));
      d = 16'($urandom);
      do_op(1, a, d, 2'b11, rd, lat);
      chk_lat("rnd_fill", lat);
    end
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      d = 16'($urandom);
      be = 2'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        do_op(1, a, d, be, rd, lat);
        chk_lat("rnd_wr", lat);
      end else begin
        want = model[widx(a)];
        do_op(0, a, d, be, rd, lat);
        chk_lat("rnd_rd", lat);
        chk_rd("rnd_rd", rd, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    int first;
    mem_address = 16'h0002;
    mem_read = 1'b1;
    first = 0;
    gap = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (mem_resp) begin
        if (first == 0) first = i;
        else begin
          gap = i - first;
          break;
        end
      end
    end
    mem_read = 1'b0;
    tick();
    tick();
    total++;
    if (first != LAT) begin
      bad++; $display("FAIL b2b_first got=%0d want=%0d", first, LAT);
    end
    total++;
    if (gap != LAT + 1) begin
      bad++; $display("FAIL b2b_gap got=%0d want=%0d", gap, LAT + 1);
    end
  endtask

  task automatic test_abort();
    logic [15:0] rd;
    int lat;
    int seen;
    do_op(1, 16'h0008, 16'h0ABC, 2'b11, rd, lat);
    mem_address = 16'h0008;
    mem_wdata = 16'h9999;
    mem_byte_enable = 2'b11;
    mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_resp) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL abort_resp got=%0d want=0", seen);
    end
    do_op(0, 16'h0008, 16'h0, 2'b00, rd, lat);
    chk_rd("abort_old", rd, 16'h0ABC);
  endtask

  task automatic test_protocol();
    logic [15:0] rd;
    int lat;
    int seen;
    mem_address = 16'h0008;
    mem_wdata = 16'h7777;
    mem_byte_enable = 2'b11;
    mem_read = 1'b1;
    mem_write = 1'b1;
    tick();
    total++;
    if (protocol_err !== 1'b1) begin
      bad++; $display("FAIL perr_set got=%b want=1", protocol_err);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_resp) seen++;
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    tick();
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL perr_resp got=%0d want=0", seen);
    end
    do_op(0, 16'h0008, 16'h0, 2'b00, rd, lat);
    chk_rd("perr_nowrite", rd, 16'h0ABC);
    total++;
    if (protocol_err !== 1'b1) begin
      bad++; $display("FAIL perr_sticky got=%b want=1", protocol_err);
    end
  endtask

  task automatic test_rst_busy();
    logic [15:0] rd;
    int lat;
    int seen;
    do_op(1, 16'h000C, 16'h6C6C, 2'b11, rd, lat);
    mem_address = 16'h000C;
    mem_wdata = 16'hDEAD;
    mem_byte_enable = 2'b11;
    mem_write = 1'b1;
    tick();
    rst = 1'b1;
    mem_write = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_resp) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL rst_busy_resp got=%0d want=0", seen);
    end
    total++;
    if (protocol_err !== 1'b0) begin
      bad++; $display("FAIL rst_err_clr got=%b want=0", protocol_err);
    end
    rst = 1'b0;
    do_op(0, 16'h000C, 16'h0, 2'b00, rd, lat);
    chk_lat("rst_next_rd", lat);
    chk_rd("rst_no_write", rd, 16'h6C6C);
  endtask

  task automatic l1_op(input bit wr, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [1:0] be,
                       output logic [15:0] rd, output int lat);
    s_addr = addr;
    s_wdata = wd;
    s_be = be;
    s_read = !wr;
    s_write = wr;
    lat = 0;
    rd = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (s_resp) begin
        lat = i;
        rd = s_rdata;
        break;
      end
    end
    s_read = 1'b0;
    s_write = 1'b0;
    tick();
  endtask

  task automatic test_latency1();
    logic [15:0] rd;
    int lat;
    l1_op(1, 16'h0100, 16'h4321, 2'b11, rd, lat);
    total++;
    if (lat != 1) begin
      bad++; $display("FAIL l1_wr latency got=%0d want=1", lat);
    end
    l1_op(1, 16'h0100, 16'h00EE, 2'b01, rd, lat);
    l1_op(0, 16'h0100, 16'h0, 2'b00, rd, lat);
    total++;
    if (lat != 1) begin
      bad++; $display("FAIL l1_rd latency got=%0d want=1", lat);
    end
    total++;
    if (rd !== 16'h43EE) begin
      bad++; $display("FAIL l1_rd rdata got=%h want=43ee", rd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_alias();
    test_random();
    test_back_to_back();
    test_abort();
    test_protocol();
    test_rst_busy();
    test_latency1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
